linescanner_line_packer: RTL and testbench
==========================================

// Module: linescanner_line_packer
// PURPOSE
//  Downstream consumer of the linescanner capture unit. Samples pixel_data on
//  pixel_clock while lval=1 and packs 4 pixels per 32-bit word.
//  Buffers the words in an internal FIFO and presents them on a valid/ready
//  stream, with m_last marking the word that ends a line.
//  Also counts lines and flags short/long lines and FIFO overflow.
// PARAMETERS
//  PIXELS_PER_LINE  1024  expected pixels per line; must be a multiple of 4, >=4
//  FIFO_DEPTH       16    FIFO depth in words; power of 2, >=4
//  LINE_CNT_W       16    width of line_count
// PORTS
//  pixel_clock  in   1           pixel clock; all logic on the rising edge
//  n_reset      in   1           asynchronous active-low reset
//  enable       in   1           allows a new line to start; sampled in IDLE only
//  lval         in   1           line valid from the sensor
//  pixel_data   in   8           pixel value, valid while lval=1
//  m_data       out  32          packed word; first pixel of a group in [7:0]
//  m_valid      out  1           FIFO not empty
//  m_ready      in   1           consumer accepts the word when m_valid&m_ready
//  m_last       out  1           m_data holds the final pixel of a line
//  line_count   out  LINE_CNT_W  lines terminated since reset; wraps at 2^W
//  line_err     out  1           sticky: last line was short or long; cleared at next line start
//  overflow     out  1           sticky until reset: a word was dropped because the FIFO was full
//  fifo_level   out  clog2(D)+1  words currently held in the FIFO
// BEHAVIOUR
//  Reset: all outputs 0; FIFO emptied; pixel/byte counters cleared; state IDLE.
//   Reset mid-line discards all partial data.
//  lval_d is lval registered on pixel_clock. Line end = lval_d&!lval.
//  FSM states and transitions:
//   IDLE     lval&enable&!lval_d -> CAPTURE.
//            On this edge: capture pixel 0, clear line_err.
//            lval already high when enable rises -> stay in IDLE until the next rising edge of lval.
//   CAPTURE  each edge with lval=1: capture a byte into lane (pix_cnt mod 4),
//            then increment pix_cnt.
//            4th byte of a group: the word {cur,b2,b1,b0} is written to the FIFO on the same edge.
//            That word has last=1 if pix_cnt==PIXELS_PER_LINE-1.
//            Full line written with lval still 1 -> DROP; set line_err.
//            lval=0 at exactly PIXELS_PER_LINE pixels -> IDLE; line_count+1.
//            lval=0 early -> FLUSH; set line_err.
//   FLUSH    (one cycle) write the partial word with last=1.
//            Missing lanes are zero. If the byte count is 0, instead set
//            last=1 on a dummy all-zero word. -> IDLE; line_count+1.
//   DROP     ignore pixels until lval=0 -> IDLE; line_count+1.
//  Write attempted while FIFO full (level==D, no simultaneous read): word dropped,
//   overflow=1, -> DROP.
//   The remainder of the line, including its last marker, is discarded.
//  FIFO: FWFT. m_data/m_last come from the head entry. Read happens on an edge
//   with m_valid&m_ready.
//   Simultaneous read and write: level unchanged; allowed when full (read frees the slot).
//   Pointers wrap modulo D; full/empty are derived from fifo_level.
//  Latency: a word is visible (m_valid=1) in the cycle after the edge that sampled its 4th pixel.
//  m_data/m_last hold stable while m_valid=1 and m_ready=0.
//  enable dropping mid-line does not abort the line.
// TESTING
//  Use PIXELS_PER_LINE=8, FIFO_DEPTH=4, m_ready=1.
//  1. Send pixels 01..08 -> words 0x04030201 (last=0), then 0x08070605 (last=1);
//     line_count=1, line_err=0.
//  2. lval high for 6 pixels A1..A6 -> 0xA4A3A2A1, then 0x0000A6A5 (last=1)
//     in the FLUSH cycle; line_err=1.
//  3. lval high for 10 pixels -> two words as in test 1; pixels 9,10 ignored;
//     line_err=1; line_count+1.
//  4. m_ready=0 for 3 lines of 8 pixels -> FIFO level reaches 4 and overflow=1;
//     then m_ready=1 -> exactly 4 words drain.
//     The next line is delivered intact.
//  5. Level 4, m_ready=1, with a write on the same edge -> no overflow; level stays 4.
//  6. n_reset low after 3 pixels -> m_valid=0, level=0, line_count=0;
//     the next full line packs from pixel 0.

Source files
------------

// File: rtl/linescanner_line_packer.sv
// linescanner_line_packer: packs 4 pixels per word from lval-framed lines into a FWFT FIFO stream with line status
module linescanner_line_packer #(
  parameter int PIXELS_PER_LINE = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int LINE_CNT_W = 16
) (
  input  logic                          pixel_clock,
  input  logic                          n_reset,
  input  logic                          enable,
  input  logic                          lval,
  input  logic [7:0]                    pixel_data,
  output logic [31:0]                   m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic [LINE_CNT_W-1:0]         line_count,
  output logic                          line_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PIXELS_PER_LINE + 1);
  localparam logic [1:0] IDLE = 2'd0, CAPTURE = 2'd1, FLUSH = 2'd2, DROP = 2'd3;
  localparam logic [CW-1:0] PPL = CW'(PIXELS_PER_LINE);
  localparam logic [CW-1:0] PPL_M1 = CW'(PIXELS_PER_LINE - 1);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  logic [1:0] state;
  logic lval_d;
  logic [CW-1:0] pix_cnt;
  logic [7:0] b0, b1, b2;
  logic [32:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [1:0] lane;
  logic cap_wr, flush_wr, wr, rd, dropped, push;
  logic [32:0] wr_word;
  always_comb begin
    lane = pix_cnt[1:0];
    m_valid = |fifo_level;
    rd = m_valid & m_ready;
    cap_wr = (state == CAPTURE) & lval & (pix_cnt != PPL) & (lane == 2'd3);
    flush_wr = state == FLUSH;
    wr = cap_wr | flush_wr;
    dropped = wr & (fifo_level == DEPTH) & ~rd;
    push = wr & ~dropped;
    wr_word = flush_wr ? {1'b1, 8'd0, lane > 2'd2 ? b2 : 8'd0, lane > 2'd1 ? b1 : 8'd0, lane > 2'd0 ? b0 : 8'd0}
                       : {pix_cnt == PPL_M1, pixel_data, b2, b1, b0};
    m_data = m_valid ? mem[rd_ptr][31:0] : 32'd0;
    m_last = m_valid & mem[rd_ptr][32];
  end
  always_ff @(posedge pixel_clock)
    if (push) mem[wr_ptr] <= wr_word;
  always_ff @(posedge pixel_clock or negedge n_reset)
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(rd);
      fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(rd);
    end
  always_ff @(posedge pixel_clock or negedge n_reset)
    if (!n_reset) begin
      state <= IDLE;
      lval_d <= 1'b0;
      pix_cnt <= '0;
      b0 <= '0;
      b1 <= '0;
      b2 <= '0;
      line_count <= '0;
      line_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      lval_d <= lval;
      if (dropped) overflow <= 1'b1;
      case (state)
        IDLE:
          if (lval & enable & ~lval_d) begin
            state <= CAPTURE;
            b0 <= pixel_data;
            pix_cnt <= CW'(1);
            line_err <= 1'b0;
          end
        CAPTURE:
          if (!lval) begin
            state <= pix_cnt == PPL ? IDLE : FLUSH;
            if (pix_cnt == PPL) line_count <= line_count + 1'b1;
            else line_err <= 1'b1;
          end else if (pix_cnt == PPL) begin
            state <= DROP;
            line_err <= 1'b1;
          end else begin
            if (lane == 2'd0) b0 <= pixel_data;
            if (lane == 2'd1) b1 <= pixel_data;
            if (lane == 2'd2) b2 <= pixel_data;
            pix_cnt <= pix_cnt + 1'b1;
            if (dropped) state <= DROP;
          end
        FLUSH: begin
          state <= IDLE;
          line_count <= line_count + 1'b1;
        end
        default:
          if (!lval) begin
            state <= IDLE;
            line_count <= line_count + 1'b1;
          end
      endcase
    end
endmodule

// File: tb/tb_linescanner_line_packer.sv
// tb_linescanner_line_packer: directed and random lines checked against a queue-based line/FIFO model
module tb_linescanner_line_packer;
  localparam int PPL = 8, D = 4;
  logic pixel_clock = 0, n_reset = 1, enable = 0, lval = 0, m_ready = 0;
  logic [7:0] pixel_data = 0;
  logic [31:0] m_data;
  logic m_valid, m_last, line_err, overflow;
  logic [15:0] line_count;
  logic [2:0] fifo_level;
  int errors = 0, checks = 0;
  logic [32:0] q[$], got[$];
  logic [7:0] grp[$];
  int cnt = 0, lines = 0;
  bit in_line = 0, dropping = 0, flushing = 0, err_m = 0, ovf_m = 0, lv_d = 0;
  linescanner_line_packer #(.PIXELS_PER_LINE(PPL), .FIFO_DEPTH(D), .LINE_CNT_W(16)) dut (
    .pixel_clock(pixel_clock), .n_reset(n_reset), .enable(enable), .lval(lval),
    .pixel_data(pixel_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .line_count(line_count), .line_err(line_err), .overflow(overflow),
    .fifo_level(fifo_level)
  );
  always #5 pixel_clock = ~pixel_clock;
  task automatic chk(string tag, logic [32:0] obs, logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [32:0] got_w(int i);
    return got.size() > i ? got[i] : '1;
  endfunction
  task automatic compare_all();
    chk("m_valid", m_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("m_data", m_data, q[0][31:0]);
      chk("m_last", m_last, q[0][32]);
    end else begin
      chk("m_data", m_data, 0);
      chk("m_last", m_last, 0);
    end
    chk("fifo_level", fifo_level, q.size());
    chk("line_count", line_count, lines & 16'hFFFF);
    chk("line_err", line_err, err_m);
    chk("overflow", overflow, ovf_m);
  endtask
  task automatic model_edge(bit lv, logic [7:0] px, bit en, bit rd);
    bit wr, drop;
    logic [32:0] w;
    wr = 0;
    w = '0;
    if (flushing) begin
      w = {1'b1, 32'd0};
      foreach (grp[i]) w[8*i +: 8] = grp[i];
      grp.delete();
      wr = 1;
      flushing = 0;
      in_line = 0;
      lines++;
    end else if (in_line && dropping) begin
      if (!lv) begin
        in_line = 0;
        dropping = 0;
        lines++;
      end
    end else if (in_line) begin
      if (!lv) begin
        if (cnt == PPL) begin
          in_line = 0;
          lines++;
        end else begin
          err_m = 1;
          flushing = 1;
        end
      end else if (cnt == PPL) begin
        dropping = 1;
        err_m = 1;
      end else begin
        grp.push_back(px);
        cnt++;
        if (grp.size() == 4) begin
          w = {cnt == PPL, grp[3], grp[2], grp[1], grp[0]};
          grp.delete();
          wr = 1;
        end
      end
    end else if (lv && en && !lv_d) begin
      in_line = 1;
      cnt = 1;
      grp.delete();
      grp.push_back(px);
      err_m = 0;
    end
    drop = wr && q.size() == D && !rd;
    if (drop) begin
      ovf_m = 1;
      if (in_line) dropping = 1;
    end
    if (rd) void'(q.pop_front());
    if (wr && !drop) q.push_back(w);
    lv_d = lv;
  endtask
  task automatic step(bit lv, logic [7:0] px, bit rdy, bit en);
    bit rd;
    lval = lv;
    pixel_data = px;
    m_ready = rdy;
    enable = en;
    rd = rdy && q.size() > 0;
    if (m_valid && m_ready) got.push_back({m_last, m_data});
    @(posedge pixel_clock);
    model_edge(lv, px, en, rd);
    #1;
    compare_all();
  endtask
  task automatic send(int n, logic [7:0] first, bit rdy);
    for (int i = 0; i < n; i++) step(1, first + 8'(i), rdy, 1);
    for (int i = 0; i < 3; i++) step(0, 0, rdy, 1);
  endtask
  task automatic do_reset();
    n_reset = 0;
    lval = 0;
    m_ready = 0;
    enable = 0;
    #3;
    q.delete();
    grp.delete();
    in_line = 0;
    dropping = 0;
    flushing = 0;
    err_m = 0;
    ovf_m = 0;
    lines = 0;
    lv_d = 0;
    cnt = 0;
    compare_all();
    @(negedge pixel_clock);
    n_reset = 1;
  endtask
  initial begin
    #1;
    do_reset();
    step(0, 0, 1, 1);
    got.delete();
    send(8, 8'h01, 1);
    chk("t1 words", got.size(), 2);
    chk("t1 w0", got_w(0), {1'b0, 32'h04030201});
    chk("t1 w1", got_w(1), {1'b1, 32'h08070605});
    chk("t1 count", line_count, 1);
    chk("t1 err", line_err, 0);
    got.delete();
    send(6, 8'hA1, 1);
    chk("t2 w0", got_w(0), {1'b0, 32'hA4A3A2A1});
    chk("t2 w1", got_w(1), {1'b1, 32'h0000A6A5});
    chk("t2 err", line_err, 1);
    got.delete();
    send(10, 8'h01, 1);
    chk("t3 words", got.size(), 2);
    chk("t3 w1", got_w(1), {1'b1, 32'h08070605});
    chk("t3 err", line_err, 1);
    chk("t3 count", line_count, 3);
    for (int i = 0; i < 3; i++) send(8, 8'h40 + 8'(16 * i), 0);
    chk("t4 level", fifo_level, 4);
    chk("t4 ovf", overflow, 1);
    got.delete();
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1);
    chk("t4 drained", got.size(), 4);
    got.delete();
    send(8, 8'h11, 1);
    chk("t4 next w0", got_w(0), {1'b0, 32'h14131211});
    chk("t4 next w1", got_w(1), {1'b1, 32'h18171615});
    do_reset();
    send(8, 8'h50, 0);
    send(8, 8'h60, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h70 + 8'(i), 0, 1);
    step(1, 8'h73, 1, 1);
    chk("t5 level", fifo_level, 4);
    chk("t5 ovf", overflow, 0);
    for (int i = 4; i < 8; i++) step(1, 8'h70 + 8'(i), 1, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 8'h90 + 8'(i), 1, 1);
    do_reset();
    chk("t6 valid", m_valid, 0);
    chk("t6 level", fifo_level, 0);
    chk("t6 count", line_count, 0);
    got.delete();
    send(8, 8'h21, 1);
    chk("t6 w0", got_w(0), {1'b0, 32'h24232221});
    chk("t6 w1", got_w(1), {1'b1, 32'h28272625});
    for (int i = 0; i < 3; i++) step(1, 8'hC0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 8'hC1, 1, 1);
    step(0, 0, 1, 1);
    for (int l = 0; l < 60; l++) begin
      int n, gap;
      n = $urandom_range(1, 11);
      gap = $urandom_range(1, 3);
      for (int i = 0; i < n; i++)
        step(1, 8'($urandom), $urandom_range(0, 3) != 0, i == 0 ? $urandom_range(0, 4) != 0 : $urandom_range(0, 1) != 0);
      for (int g = 0; g < gap; g++) step(0, 0, $urandom_range(0, 3) != 0, 1);
    end
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
